// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch stage: sequential PC requests, in-order response buffer, redirect flush
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic [6:0]  out_opcode
);
    localparam int            AW      = $clog2(DEPTH);
    localparam int            CW      = AW + 1;
    localparam logic [CW:0]   CAP     = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0] ONE     = CW'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] pq_wr_q, pq_wr_d, pq_rd_q, pq_rd_d;
    logic [AW-1:0] of_wr_q, of_wr_d, of_rd_q, of_rd_d;
    logic [31:0]   pq_mem_q   [DEPTH];
    logic [31:0]   of_pc_q    [DEPTH];
    logic [31:0]   of_instr_q [DEPTH];

    logic          req_fire, rsp_take, rsp_keep, pop;
    logic [CW:0]   occupancy;

    always_comb begin
        pop       = (cnt_q != '0) && out_ready && !redirect_valid;
        // A slot popped this cycle is free before any new response can land, so it is credited
        // here; this is what sustains one instruction per cycle with DEPTH=2.
        occupancy = {1'b0, inflight_q} + {1'b0, cnt_q} - {{CW{1'b0}}, pop};
        imem_req_valid = !rst && !redirect_valid && (occupancy < CAP);
        imem_req_addr  = pc_q;
        req_fire  = imem_req_valid && imem_req_ready;
        rsp_take  = imem_rsp_valid && (inflight_q != '0);
        rsp_keep  = rsp_take && (drop_q == '0) && !redirect_valid;

        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = redirect_pc & ~32'h0000_0003;
        end else if (req_fire) begin
            pc_d = pc_q + 32'd4;
        end

        inflight_d = inflight_q;
        if (req_fire && !rsp_take) begin
            inflight_d = inflight_q + ONE;
        end else if (!req_fire && rsp_take) begin
            inflight_d = inflight_q - ONE;
        end

        // Every request still outstanding after a redirect belongs to the abandoned path.
        drop_d = drop_q;
        if (redirect_valid) begin
            drop_d = inflight_d;
        end else if (rsp_take && (drop_q != '0)) begin
            drop_d = drop_q - ONE;
        end

        pq_wr_d = req_fire ? pq_wr_q + PTR_ONE : pq_wr_q;
        pq_rd_d = rsp_take ? pq_rd_q + PTR_ONE : pq_rd_q;

        of_wr_d = of_wr_q;
        of_rd_d = of_rd_q;
        cnt_d   = cnt_q;
        if (redirect_valid) begin
            of_wr_d = '0;
            of_rd_d = '0;
            cnt_d   = '0;
        end else begin
            if (rsp_keep) of_wr_d = of_wr_q + PTR_ONE;
            if (pop)      of_rd_d = of_rd_q + PTR_ONE;
            if (rsp_keep && !pop) begin
                cnt_d = cnt_q + ONE;
            end else if (!rsp_keep && pop) begin
                cnt_d = cnt_q - ONE;
            end
        end

        out_valid  = (cnt_q != '0);
        out_pc     = of_pc_q[of_rd_q];
        out_instr  = of_instr_q[of_rd_q];
        out_opcode = out_instr[6:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            inflight_q <= '0;
            drop_q     <= '0;
            cnt_q      <= '0;
            pq_wr_q    <= '0;
            pq_rd_q    <= '0;
            of_wr_q    <= '0;
            of_rd_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pq_mem_q[i]   <= '0;
                of_pc_q[i]    <= '0;
                of_instr_q[i] <= '0;
            end
        end else begin
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            cnt_q      <= cnt_d;
            pq_wr_q    <= pq_wr_d;
            pq_rd_q    <= pq_rd_d;
            of_wr_q    <= of_wr_d;
            of_rd_q    <= of_rd_d;
            if (req_fire) begin
                pq_mem_q[pq_wr_q] <= pc_q;
            end
            if (rsp_keep) begin
                of_pc_q[of_wr_q]    <= pq_mem_q[pq_rd_q];
                of_instr_q[of_wr_q] <= imem_rsp_data;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - scoreboard bench for instr_fetch with an in-order variable-latency memory model
module tb_instr_fetch;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } pend_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [6:0]  out_opcode;

    pend_t       pend[$];
    exp_t        expq[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          epoch = 0;
    int          n_acc = 0;
    int          n_out = 0;
    int          n_wrap = 0;
    int          lat_fix = 1;
    bit          lat_rand = 1'b0;
    bit          rand_ready = 1'b0;
    int          bogus_req = 0;
    logic [31:0] last_out_pc = '0;

    instr_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instr(out_instr), .out_opcode(out_opcode)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory model and expected-stream producer: pushes {pc, word} when a live response is delivered.
    initial begin : mem_model
        pend_t       cur;
        pend_t       nw;
        bit          rsp_now;
        int          last_due;
        int          bogus_done;
        logic [31:0] exp_addr;
        logic [31:0] last_acc;
        last_due       = 0;
        bogus_done     = 0;
        exp_addr       = RESET_PC;
        last_acc       = '0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            cyc++;
            rsp_now        = 1'b0;
            imem_rsp_valid = 1'b0;
            if (!rst && bogus_req != bogus_done) begin
                bogus_done++;
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = 32'hDEAD_BEEF;
            end else if (!rst && pend.size() > 0 && pend[0].due <= cyc) begin
                cur            = pend.pop_front();
                rsp_now        = 1'b1;
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = word_at(cur.addr);
            end
            imem_req_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            #2;
            if (rst) begin
                pend.delete();
                expq.delete();
                epoch++;
                exp_addr = RESET_PC;
            end else if (redirect_valid) begin
                chk("req_valid_in_redirect", 32'(imem_req_valid), 32'd0);
                epoch++;
                expq.delete();
                exp_addr = redirect_pc & ~32'h3;
            end else begin
                if (imem_req_valid && imem_req_ready) begin
                    chk("req_addr", imem_req_addr, exp_addr);
                    if (last_acc == 32'hFFFF_FFFC && imem_req_addr == 32'h0) n_wrap++;
                    last_acc = imem_req_addr;
                    nw.addr  = imem_req_addr;
                    nw.epoch = epoch;
                    nw.due   = cyc + (lat_rand ? $urandom_range(1, 4) : lat_fix);
                    if (nw.due <= last_due) nw.due = last_due + 1;
                    last_due = nw.due;
                    pend.push_back(nw);
                    exp_addr = exp_addr + 32'd4;
                    n_acc++;
                end
                if (rsp_now && cur.epoch == epoch) begin
                    expq.push_back('{pc: cur.addr, instr: word_at(cur.addr)});
                end
            end
        end
    end

    // Monitor: pops the scoreboard on every decode handshake.
    initial begin : monitor
        exp_t e;
        bit   seq_ok;
        seq_ok = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst && !redirect_valid && out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL out_unexpected: got pc %h instr %h, expected no output", out_pc, out_instr);
                end else begin
                    e = expq.pop_front();
                    chk("out_pc", out_pc, e.pc);
                    chk("out_instr", out_instr, e.instr);
                    chk("out_opcode", 32'(out_opcode), 32'(e.instr[6:0]));
                    if (seq_ok) chk("out_pc_step", out_pc, last_out_pc + 32'd4);
                end
                last_out_pc = out_pc;
                seq_ok      = 1'b1;
                n_out++;
            end
            if (rst || redirect_valid) seq_ok = 1'b0;
        end
    end

    task automatic wait_out(input string name, input logic [31:0] exp_pc);
        int start;
        start = n_out;
        for (int i = 0; i < 100 && n_out == start; i++) begin
            @(negedge clk);
            #3;
        end
        if (n_out == start) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: no output within 100 cycles, expected pc %h", name, exp_pc);
        end else begin
            chk(name, last_out_pc, exp_pc);
        end
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got %0d vectors expected completion", n_vec);
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int acc0;
        int out0;
        int wrap0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b1;
        #2;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_pc", out_pc, 32'd0);
        chk("rst_out_instr", out_instr, 32'd0);
        chk("rst_out_opcode", 32'(out_opcode), 32'd0);
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_req_addr", imem_req_addr, RESET_PC);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;

        // 1: single-cycle memory, first instruction in cycle 3 then one per cycle
        @(negedge clk); #1;
        @(negedge clk); #1;
        chk("t1_no_bypass_c2", 32'(out_valid), 32'd0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk); #1;
            chk("t1_stream_valid", 32'(out_valid), 32'd1);
            chk("t1_stream_pc", out_pc, RESET_PC + 32'(4 * k));
        end

        // 2: decode stalls for 10 cycles
        @(negedge clk);
        out_ready = 1'b0;
        acc0 = n_acc;
        repeat (9) @(negedge clk);
        #3;
        chk("t2_accepts_le_depth", 32'(n_acc - acc0 <= DEPTH), 32'd1);
        chk("t2_req_valid_held", 32'(imem_req_valid), 32'd0);
        chk("t2_out_valid_held", 32'(out_valid), 32'd1);
        @(negedge clk);
        out_ready = 1'b1;
        repeat (6) @(negedge clk);

        // 3: redirect with two requests outstanding
        lat_fix = 3;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk); #3;
            if (pend.size() == 2) break;
        end
        chk("t3_two_inflight", 32'(pend.size()), 32'd2);
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        @(negedge clk);
        redirect_valid = 1'b0;
        wait_out("t3_first_pc", 32'h0000_0100);

        // 4: redirect coinciding with a response and a decode pop
        lat_fix = 1;
        repeat (8) @(negedge clk);
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        #1;
        chk("t4_rsp_in_r", 32'(imem_rsp_valid), 32'd1);
        chk("t4_out_valid_in_r", 32'(out_valid), 32'd1);
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        chk("t4_fifo_empty_r1", 32'(out_valid), 32'd0);
        chk("t4_req_valid_r1", 32'(imem_req_valid), 32'd1);
        chk("t4_req_addr_r1", imem_req_addr, 32'h0000_0200);
        @(negedge clk); #1;
        chk("t4_empty_r2", 32'(out_valid), 32'd0);
        @(negedge clk); #1;
        chk("t4_valid_r3", 32'(out_valid), 32'd1);
        chk("t4_pc_r3", out_pc, 32'h0000_0200);
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0300;
        @(negedge clk);
        redirect_pc    = 32'h0000_0402;
        @(negedge clk);
        redirect_valid = 1'b0;
        wait_out("t4_b2b_last_wins", 32'h0000_0400);

        // 5: random ready, 1-4 cycle latency, random decode stalls and occasional redirects
        lat_rand   = 1'b1;
        rand_ready = 1'b1;
        out0 = n_out;
        for (int i = 0; i < 20000 && (n_out - out0) < 1000; i++) begin
            @(negedge clk);
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 63) == 0) begin
                redirect_valid = 1'b1;
                redirect_pc    = $urandom() & 32'h0003_FFFF;
            end else begin
                redirect_valid = 1'b0;
            end
        end
        @(negedge clk);
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        chk("t5_1000_instrs", 32'(n_out - out0 >= 1000), 32'd1);

        // 6: PC wrap, then asynchronous reset mid-burst
        lat_rand   = 1'b0;
        rand_ready = 1'b0;
        lat_fix    = 1;
        repeat (6) @(negedge clk);
        wrap0 = n_wrap;
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        @(negedge clk);
        redirect_valid = 1'b0;
        wait_out("t6_first_pc", 32'hFFFF_FFF8);
        repeat (4) @(negedge clk);
        chk("t6_wrap_seen", 32'(n_wrap - wrap0), 32'd1);
        @(negedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("t6_arst_out_valid", 32'(out_valid), 32'd0);
        chk("t6_arst_out_pc", out_pc, 32'd0);
        chk("t6_arst_out_instr", out_instr, 32'd0);
        chk("t6_arst_out_opcode", 32'(out_opcode), 32'd0);
        chk("t6_arst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("t6_arst_req_addr", imem_req_addr, RESET_PC);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        bogus_req++;
        #1;
        rst = 1'b0;
        wait_out("t6_after_reset_pc", RESET_PC);
        repeat (8) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
